transmissor_face_serial: RTL and testbench

Transmit side of the cube-face serial link. On a start pulse, the block reads the 3x3 sample memory cell by cell and sends each 16-bit sample as two 8N1 UART bytes, MSB byte first. It sits between the 3x3 face RAM read port and the serial TX pin. It produces the byte stream that the face receiver reassembles with its pixel register.

---
 rtl/face_serial_pkg.sv | 31 +++
 rtl/uart_tx_byte.sv | 120 ++++++++++++
 rtl/transmissor_face_serial.sv | 190 +++++++++++++++++++
 tb/tb_transmissor_face_serial.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/face_serial_pkg.sv
// Shared constants for the cube-face serial transmitter: FSM state codes,
// face geometry, UART idle level and the checksum update helper.
package face_serial_pkg;

    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_READ  = 4'd1;
    localparam logic [3:0] ST_LATCH = 4'd2;
    localparam logic [3:0] ST_START = 4'd3;
    localparam logic [3:0] ST_DATA  = 4'd4;
    localparam logic [3:0] ST_STOP  = 4'd5;
    localparam logic [3:0] ST_NEXT  = 4'd6;
    localparam logic [3:0] ST_DONE  = 4'd7;
    localparam logic [3:0] ST_CHK   = 4'd8;

    localparam int FACE_ROWS      = 3;
    localparam int FACE_COLS      = 3;
    localparam int BYTES_PER_CELL = 2;

    localparam logic UART_IDLE = 1'b1;

    // Byte-serial phases of the shifter.
    localparam logic [1:0] PH_IDLE  = 2'd0;
    localparam logic [1:0] PH_START = 2'd1;
    localparam logic [1:0] PH_DATA  = 2'd2;
    localparam logic [1:0] PH_STOP  = 2'd3;

    function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte shifter with bit timer. A load accepted in the last stop-bit cycle
// chains the next byte with no idle gap between stop and start bits.
module uart_tx_byte
    import face_serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] byte_in,
    output logic       busy,
    output logic       done,
    output logic       txd
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TMR_LAST = TW'(CLKS_PER_BIT - 1);

    logic [1:0]    phase_q, phase_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          bit_end_s;

    assign bit_end_s = (tmr_q == TMR_LAST);
    assign busy      = (phase_q != PH_IDLE);
    assign done      = (phase_q == PH_STOP) && bit_end_s;
    assign txd       = txd_q;

    // Next-state for phase, bit timer, bit counter and shift register.
    always_comb begin
        phase_d = phase_q;
        tmr_d   = tmr_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (phase_q)
            PH_IDLE: begin
                tmr_d = {TW{1'b0}};
                if (load) begin
                    phase_d = PH_START;
                    shift_d = byte_in;
                    bit_d   = 3'd0;
                end else begin
                    phase_d = PH_IDLE;
                end
            end
            PH_START: begin
                if (bit_end_s) begin
                    tmr_d   = {TW{1'b0}};
                    bit_d   = 3'd0;
                    phase_d = PH_DATA;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            PH_DATA: begin
                if (bit_end_s) begin
                    tmr_d   = {TW{1'b0}};
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
                        phase_d = PH_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            PH_STOP: begin
                if (bit_end_s) begin
                    tmr_d = {TW{1'b0}};
                    if (load) begin
                        phase_d = PH_START;
                        shift_d = byte_in;
                        bit_d   = 3'd0;
                    end else begin
                        phase_d = PH_IDLE;
                    end
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            default: begin
                phase_d = PH_IDLE;
                tmr_d   = {TW{1'b0}};
                bit_d   = 3'd0;
            end
        endcase
    end

    // Line level follows the next phase so txd is a clean flop output.
    always_comb begin
        case (phase_d)
            PH_START: txd_d = 1'b0;
            PH_DATA:  txd_d = shift_d[0];
            default:  txd_d = UART_IDLE;
        endcase
    end

    // Shifter state registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q <= PH_IDLE;
            tmr_q   <= {TW{1'b0}};
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            txd_q   <= UART_IDLE;
        end else begin
            phase_q <= phase_d;
            tmr_q   <= tmr_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

endmodule

// File: rtl/transmissor_face_serial.sv
// Face transmitter: walks the 3x3 RAM row-major and sends each sample as two
// 8N1 bytes, MSB first. Define TX_CHECKSUM_EN to append an XOR checksum byte.
module transmissor_face_serial
    import face_serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int S_DATA       = 16,
    parameter int ROWS         = FACE_ROWS,
    parameter int COLS         = FACE_COLS
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              partida,
    input  logic [S_DATA-1:0] q_pixel,
    output logic [1:0]        addr_line,
    output logic [1:0]        addr_column,
    output logic              saida_serial,
    output logic              ocupado,
    output logic              pronto,
    output logic [3:0]        db_estado
);

    logic [3:0] state_q, state_d;
    logic [1:0] row_q, row_d;
    logic [1:0] col_q, col_d;
    logic [7:0] lo_q, lo_d;
    logic       byte_sel_q, byte_sel_d;
    logic       ocupado_q, ocupado_d;
    logic       pronto_q, pronto_d;
    logic       uart_load_s;
    logic [7:0] uart_byte_s;
    logic       uart_busy_s;
    logic       uart_done_s;
    logic       last_cell_s;
`ifdef TX_CHECKSUM_EN
    logic [7:0] chk_q, chk_d;
`endif

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .clock   (clock),
        .reset   (reset),
        .load    (uart_load_s),
        .byte_in (uart_byte_s),
        .busy    (uart_busy_s),
        .done    (uart_done_s),
        .txd     (saida_serial)
    );

    assign last_cell_s = (row_q == 2'(ROWS - 1)) && (col_q == 2'(COLS - 1));
    assign addr_line   = row_q;
    assign addr_column = col_q;
    assign ocupado     = ocupado_q;
    assign pronto      = pronto_q;
    assign db_estado   = state_q;

    // Frame sequencer: addresses, byte selection and shifter loads.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        lo_d        = lo_q;
        byte_sel_d  = byte_sel_q;
        uart_load_s = 1'b0;
        uart_byte_s = 8'h00;
`ifdef TX_CHECKSUM_EN
        chk_d       = chk_q;
`endif
        case (state_q)
            ST_IDLE: begin
                row_d      = 2'd0;
                col_d      = 2'd0;
                byte_sel_d = 1'b0;
`ifdef TX_CHECKSUM_EN
                chk_d      = 8'h00;
`endif
                if (partida) begin
                    state_d = ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                lo_d        = q_pixel[7:0];
                uart_load_s = 1'b1;
                uart_byte_s = q_pixel[15:8];
                byte_sel_d  = 1'b0;
`ifdef TX_CHECKSUM_EN
                chk_d       = chk_update(chk_q, q_pixel[15:8]);
`endif
                state_d     = ST_START;
            end
            ST_START: begin
                if (uart_done_s) begin
                    if (!byte_sel_q) begin
                        uart_load_s = 1'b1;
                        uart_byte_s = lo_q;
                        byte_sel_d  = 1'b1;
`ifdef TX_CHECKSUM_EN
                        chk_d       = chk_update(chk_q, lo_q);
`endif
                    end else begin
                        state_d = ST_NEXT;
                    end
                end else if (!uart_busy_s) begin
                    // Shifter lost its byte (should not happen): abandon the frame.
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_NEXT: begin
                if (last_cell_s) begin
`ifdef TX_CHECKSUM_EN
                    uart_load_s = 1'b1;
                    uart_byte_s = chk_q;
                    state_d     = ST_CHK;
`else
                    state_d     = ST_DONE;
`endif
                end else begin
                    if (col_q == 2'(COLS - 1)) begin
                        col_d = 2'd0;
                        row_d = row_q + 2'd1;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                    state_d = ST_READ;
                end
            end
`ifdef TX_CHECKSUM_EN
            ST_CHK: begin
                if (uart_done_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CHK;
                end
            end
`endif
            ST_DONE: begin
                row_d   = 2'd0;
                col_d   = 2'd0;
                state_d = ST_IDLE;
            end
            default: begin
                row_d   = 2'd0;
                col_d   = 2'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs are flopped from the next state.
    always_comb begin
        ocupado_d = (state_d != ST_IDLE);
        pronto_d  = (state_d == ST_DONE);
    end

    // Sequencer registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            row_q      <= 2'd0;
            col_q      <= 2'd0;
            lo_q       <= 8'h00;
            byte_sel_q <= 1'b0;
            ocupado_q  <= 1'b0;
            pronto_q   <= 1'b0;
`ifdef TX_CHECKSUM_EN
            chk_q      <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            lo_q       <= lo_d;
            byte_sel_q <= byte_sel_d;
            ocupado_q  <= ocupado_d;
            pronto_q   <= pronto_d;
`ifdef TX_CHECKSUM_EN
            chk_q      <= chk_d;
`endif
        end
    end

endmodule

// File: tb/tb_transmissor_face_serial.sv
// Directed bench for transmissor_face_serial with CLKS_PER_BIT=4, a 1-cycle
// latency RAM model and a UART monitor decoding the serial line.
module tb_transmissor_face_serial;

    localparam int CPB = 4;
`ifdef TX_CHECKSUM_EN
    localparam int NBYTES = 19;
`else
    localparam int NBYTES = 18;
`endif
    localparam int BOUND = 3000;

    logic        clock;
    logic        reset;
    logic        partida;
    logic [15:0] q_pixel;
    logic [1:0]  addr_line;
    logic [1:0]  addr_column;
    logic        saida_serial;
    logic        ocupado;
    logic        pronto;
    logic [3:0]  db_estado;

    logic [15:0] mem [0:8];
    logic [7:0]  rx_q [$];
    int          checks;
    int          errors;
    int          pronto_cnt;
    int          stop_errs;
    bit          mon_active;
    int          mon_cnt;
    logic [7:0]  mon_sh;

    transmissor_face_serial #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .partida      (partida),
        .q_pixel      (q_pixel),
        .addr_line    (addr_line),
        .addr_column  (addr_column),
        .saida_serial (saida_serial),
        .ocupado      (ocupado),
        .pronto       (pronto),
        .db_estado    (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM read port, one cycle of latency
    always @(posedge clock) begin
        q_pixel <= mem[int'(addr_line) * 3 + int'(addr_column)];
    end

    // Pronto pulse counter
    always @(negedge clock) begin
        if (pronto === 1'b1) pronto_cnt <= pronto_cnt + 1;
    end

    // UART monitor: offset 0 = first low sample; bit i sampled at 6+4i, stop at 38
    always @(negedge clock) begin
        if (reset) begin
            mon_active <= 1'b0;
            mon_cnt    <= 0;
        end else if (!mon_active) begin
            if (saida_serial === 1'b0) begin
                mon_active <= 1'b1;
                mon_cnt    <= 1;
            end
        end else begin
            mon_cnt <= mon_cnt + 1;
            if (mon_cnt >= 6 && mon_cnt <= 34 && ((mon_cnt - 6) % 4) == 0)
                mon_sh[(mon_cnt - 6) / 4] <= saida_serial;
            if (mon_cnt == 38) begin
                mon_active <= 1'b0;
                rx_q.push_back(mon_sh);
                if (saida_serial !== 1'b1) stop_errs <= stop_errs + 1;
            end
        end
    end

    task automatic do_reset();
        reset   = 1'b1;
        partida = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        partida = 1'b1;
        @(negedge clock);
        partida = 1'b0;
    endtask

    task automatic load_pattern();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                mem[r * 3 + c] = {4'(r), 4'(c), 8'hA5};
    endtask

    function automatic logic [7:0] exp_byte(input int k);
        logic [15:0] w;
        logic [7:0]  x;
        if (k < 18) begin
            w = mem[k / 2];
            return (k % 2 == 0) ? w[15:8] : w[7:0];
        end
        x = 8'h00;
        for (int i = 0; i < 9; i++) x = x ^ mem[i][15:8] ^ mem[i][7:0];
        return x;
    endfunction

    task automatic test_reset();
        int base;
        do_reset();
        checks++;
        if (saida_serial !== 1'b1 || ocupado !== 1'b0 || pronto !== 1'b0 ||
            addr_line !== 2'd0 || addr_column !== 2'd0 || db_estado !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: got tx=%b ocup=%b pronto=%b addr=(%0d,%0d) st=%0d, want 1 0 0 (0,0) 0",
                     saida_serial, ocupado, pronto, addr_line, addr_column, db_estado);
        end
        base = pronto_cnt;
        repeat (100) @(negedge clock);
        checks++;
        if (pronto_cnt != base || saida_serial !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle: got %0d pronto pulses tx=%b, want 0 and tx=1", pronto_cnt - base, saida_serial);
        end
    endtask

    task automatic test_bit_timing();
        logic [42:0] obs;
        logic [42:0] exp;
        logic [7:0]  b;
        do_reset();
        for (int i = 0; i < 9; i++) mem[i] = 16'h0000;
        mem[0] = 16'h8001;
        b = 8'h80;
        for (int k = 0; k < 43; k++) begin
            if (k < 2) exp[k] = 1'b1;
            else if (k < 6) exp[k] = 1'b0;
            else if (k < 38) exp[k] = b[(k - 6) / 4];
            else if (k < 42) exp[k] = 1'b1;
            else exp[k] = 1'b0;
        end
        partida = 1'b1;
        @(negedge clock);
        partida = 1'b0;
        for (int k = 0; k < 43; k++) begin
            obs[k] = saida_serial;
            @(negedge clock);
        end
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL bit_timing: got %b, want %b (bit k = negedge k after partida edge)", obs, exp);
        end
    endtask

    task automatic test_full_frame();
        int base;
        int st_base;
        int i;
        do_reset();
        load_pattern();
        rx_q.delete();
        base    = pronto_cnt;
        st_base = stop_errs;
        pulse_start();
        for (i = 0; i < BOUND && pronto !== 1'b1; i++) @(negedge clock);
        checks++;
        if (pronto !== 1'b1) begin
            errors++;
            $display("FAIL frame_pronto_timeout: got no pronto in %0d cycles, want one", BOUND);
        end
        @(negedge clock);
        checks++;
        if (pronto !== 1'b0 || ocupado !== 1'b0 || db_estado !== 4'd0) begin
            errors++;
            $display("FAIL frame_end: got pronto=%b ocupado=%b st=%0d after pulse, want 0 0 0", pronto, ocupado, db_estado);
        end
        repeat (60) @(negedge clock);
        checks++;
        if (rx_q.size() != NBYTES || pronto_cnt - base != 1 || stop_errs != st_base) begin
            errors++;
            $display("FAIL frame_count: got %0d bytes %0d pronto %0d stop errs, want %0d 1 0",
                     rx_q.size(), pronto_cnt - base, stop_errs - st_base, NBYTES);
        end
        for (int k = 0; k < NBYTES && k < rx_q.size(); k++) begin
            checks++;
            if (rx_q[k] !== exp_byte(k)) begin
                errors++;
                $display("FAIL frame_byte[%0d]: got %h, want %h", k, rx_q[k], exp_byte(k));
            end
        end
    endtask

    task automatic test_ignored_start();
        int base;
        int i;
        do_reset();
        load_pattern();
        rx_q.delete();
        base = pronto_cnt;
        pulse_start();
        for (i = 0; i < BOUND && rx_q.size() < 4; i++) @(negedge clock);
        repeat (10) @(negedge clock);
        pulse_start();
        for (i = 0; i < BOUND && pronto !== 1'b1; i++) @(negedge clock);
        checks++;
        if (pronto !== 1'b1) begin
            errors++;
            $display("FAIL ignore_pronto_timeout: got no pronto, want one");
        end
        // partida coinciding with the DONE cycle must be dropped
        partida = 1'b1;
        @(negedge clock);
        partida = 1'b0;
        @(negedge clock);
        checks++;
        if (ocupado !== 1'b0 || db_estado !== 4'd0) begin
            errors++;
            $display("FAIL ignore_done_start: got ocupado=%b st=%0d, want 0 0", ocupado, db_estado);
        end
        repeat (60) @(negedge clock);
        checks++;
        if (rx_q.size() != NBYTES || pronto_cnt - base != 1) begin
            errors++;
            $display("FAIL ignore_count: got %0d bytes %0d pronto, want %0d 1", rx_q.size(), pronto_cnt - base, NBYTES);
        end
        rx_q.delete();
        pulse_start();
        for (i = 0; i < BOUND && pronto !== 1'b1; i++) @(negedge clock);
        repeat (60) @(negedge clock);
        checks++;
        if (rx_q.size() != NBYTES || pronto_cnt - base != 2) begin
            errors++;
            $display("FAIL refire_count: got %0d bytes %0d pronto, want %0d 2", rx_q.size(), pronto_cnt - base, NBYTES);
        end else begin
            checks++;
            if (rx_q[0] !== 8'h00 || rx_q[17] !== 8'hA5 || rx_q[16] !== 8'h22) begin
                errors++;
                $display("FAIL refire_bytes: got %h %h %h, want 00 22 A5", rx_q[0], rx_q[16], rx_q[17]);
            end
        end
    endtask

    task automatic test_mid_reset();
        int base;
        int i;
        do_reset();
        load_pattern();
        rx_q.delete();
        base = pronto_cnt;
        pulse_start();
        for (i = 0; i < BOUND && rx_q.size() < 6; i++) @(negedge clock);
        repeat (15) @(negedge clock);
        checks++;
        if (db_estado !== 4'd3 || ocupado !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre: got st=%0d ocupado=%b, want 3 1", db_estado, ocupado);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (saida_serial !== 1'b1 || ocupado !== 1'b0 || db_estado !== 4'd0 ||
            addr_line !== 2'd0 || addr_column !== 2'd0 || pronto !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: got tx=%b ocup=%b st=%0d addr=(%0d,%0d) pronto=%b, want 1 0 0 (0,0) 0",
                     saida_serial, ocupado, db_estado, addr_line, addr_column, pronto);
        end
        repeat (100) @(negedge clock);
        checks++;
        if (pronto_cnt != base || ocupado !== 1'b0) begin
            errors++;
            $display("FAIL midreset_quiet: got %0d pronto ocupado=%b, want 0 0", pronto_cnt - base, ocupado);
        end
    endtask

`ifdef TX_CHECKSUM_EN
    task automatic test_checksum();
        int i;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            for (int k = 0; k < 9; k++) mem[k] = (pass == 0) ? 16'h0F0F : 16'h0000;
            if (pass == 1) mem[0] = 16'h0100;
            rx_q.delete();
            pulse_start();
            for (i = 0; i < BOUND && pronto !== 1'b1; i++) @(negedge clock);
            repeat (20) @(negedge clock);
            checks++;
            if (rx_q.size() != 19) begin
                errors++;
                $display("FAIL chk_count[%0d]: got %0d bytes, want 19", pass, rx_q.size());
            end else begin
                checks++;
                if (rx_q[18] !== ((pass == 0) ? 8'h00 : 8'h01)) begin
                    errors++;
                    $display("FAIL chk_byte[%0d]: got %h, want %h", pass, rx_q[18], (pass == 0) ? 8'h00 : 8'h01);
                end
            end
        end
    endtask
`endif

    initial begin
        checks     = 0;
        errors     = 0;
        pronto_cnt = 0;
        stop_errs  = 0;
        mon_active = 1'b0;
        mon_cnt    = 0;
        mon_sh     = 8'h00;
        reset      = 1'b1;
        partida    = 1'b0;
        for (int i = 0; i < 9; i++) mem[i] = 16'h0000;
        @(negedge clock);
        test_reset();
        test_bit_timing();
        test_full_frame();
        test_ignored_start();
        test_mid_reset();
`ifdef TX_CHECKSUM_EN
        test_checksum();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
